// File: rtl/pmc_pkg.sv
// Shared types and helpers for the performance-monitoring counter bank.
package pmc_pkg;

    localparam int unsigned CNT_W_DEF  = 32;
    localparam int unsigned FRAC_W_DEF = 8;
    // Widest readout bus the zero-extension helper can produce.
    localparam int unsigned OUT_W_MAX  = 1024;

    typedef enum logic [1:0] {
        StIdle,
        StDiv,
        StDone
    } pmc_state_e;

    // Keep the low `width` bits of val and force everything above to zero.
    function automatic logic [OUT_W_MAX-1:0] zext(input logic [OUT_W_MAX-1:0] val,
                                                   input int unsigned width);
        logic [OUT_W_MAX-1:0] ones;
        ones = '1;
        return val & ~(ones << width);
    endfunction

endpackage

// File: rtl/pmc_bank_if.sv
// Control/readout bundle of the counter bank; master drives controls, slave is the bank.
interface pmc_bank_if #(
    parameter int unsigned NUM_CH = 8,
    parameter int unsigned OUT_W  = 256,
    parameter int unsigned SEL_W  = $clog2(NUM_CH)
);

    logic              en;
    logic [NUM_CH-1:0] event_in;
    logic              sat_mode;
    logic              freeze;
    logic              clear;
    logic              snap_req;
    logic [SEL_W-1:0]  rd_sel;
    logic [OUT_W-1:0]  rd_data;
    logic [NUM_CH-1:0] ovf;
    logic              busy;
    logic [OUT_W-1:0]  ratio;
    logic              ratio_valid;
    logic              div0;

    modport master (
        output en, event_in, sat_mode, freeze, clear, snap_req, rd_sel,
        input  rd_data, ovf, busy, ratio, ratio_valid, div0
    );

    modport slave (
        input  en, event_in, sat_mode, freeze, clear, snap_req, rd_sel,
        output rd_data, ovf, busy, ratio, ratio_valid, div0
    );

endinterface

// File: rtl/pmc_seq_divider.sv
// Restoring divider, one quotient bit per cycle MSB first; zero divisor finishes at once
// with an all-ones quotient.
module pmc_seq_divider #(
    parameter int unsigned Q_W = 40
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [Q_W-1:0] dividend,
    input  logic [Q_W-1:0] divisor,
    output logic           busy,
    output logic           done,
    output logic [Q_W-1:0] quotient,
    output logic           div0
);

    localparam int unsigned IW = $clog2(Q_W + 1);

    logic [Q_W-1:0] rem_q;
    logic [Q_W-1:0] dvd_q;
    logic [Q_W-1:0] dvs_q;
    logic [IW-1:0]  iter_q;
    logic           busy_q;
    logic           div0_q;

    // One extra bit keeps the shifted remainder from overflowing before the compare.
    logic [Q_W:0] rem_shift;
    logic         take;

    always_comb begin
        rem_shift = {rem_q, dvd_q[Q_W-1]};
        take      = rem_shift >= {1'b0, dvs_q};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_q  <= '0;
            dvd_q  <= '0;
            dvs_q  <= '0;
            iter_q <= '0;
            busy_q <= 1'b0;
            div0_q <= 1'b0;
        end else if (start) begin
            rem_q  <= '0;
            dvd_q  <= (divisor == '0) ? '1 : dividend;
            dvs_q  <= divisor;
            iter_q <= IW'(Q_W);
            busy_q <= 1'b1;
            div0_q <= (divisor == '0);
        end else if (busy_q) begin
            if (div0_q) begin
                busy_q <= 1'b0;
            end else begin
                // dvd_q shifts out dividend bits and shifts in quotient bits.
                rem_q  <= Q_W'(take ? rem_shift - {1'b0, dvs_q} : rem_shift);
                dvd_q  <= {dvd_q[Q_W-2:0], take};
                iter_q <= iter_q - IW'(1);
                if (iter_q == IW'(1)) begin
                    busy_q <= 1'b0;
                end
            end
        end
    end

    assign done     = busy_q && (div0_q || (iter_q == IW'(1)));
    assign busy     = busy_q;
    assign quotient = dvd_q;
    assign div0     = div0_q;

endmodule

// File: rtl/pmc_bank.sv
// Performance-monitoring counter bank: event counters, atomic shadow snapshot and a
// fixed-point ratio of two snapshotted channels.
module pmc_bank
    import pmc_pkg::*;
#(
    parameter int unsigned NUM_CH  = 8,
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned FRAC_W  = FRAC_W_DEF,
    parameter int unsigned OUT_W   = 256,
    parameter int unsigned NUM_IDX = 0,
    parameter int unsigned DEN_IDX = 1
) (
    input logic       clk,
    input logic       reset,
    pmc_bank_if.slave bus
);

    localparam int unsigned Q_W = CNT_W + FRAC_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]  cnt [NUM_CH];
    logic [NUM_CH-1:0] ovf_vec;
    logic              count_en;

    assign count_en = bus.en && !bus.freeze;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] cnt_q;
        logic             ovf_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt_q <= '0;
                ovf_q <= 1'b0;
            end else if (bus.clear) begin
                cnt_q <= '0;
                ovf_q <= 1'b0;
            end else if (count_en && bus.event_in[i]) begin
                if (cnt_q == CNT_MAX) begin
                    ovf_q <= 1'b1;
                    if (!bus.sat_mode) begin
                        cnt_q <= '0;
                    end
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end

        assign cnt[i]     = cnt_q;
        assign ovf_vec[i] = ovf_q;
    end

    pmc_state_e       state_q;
    logic [CNT_W-1:0] shadow_q [NUM_CH];
    logic [Q_W-1:0]   ratio_q;
    logic             busy_q;
    logic             ratio_valid_q;
    logic             div0_q;

    logic           div_start;
    logic           div_busy;
    logic           div_done;
    logic           div_div0;
    logic [Q_W-1:0] div_quotient;
    logic [Q_W-1:0] dividend;
    logic [Q_W-1:0] divisor;

    // The divider latches the same pre-edge counts that the shadows capture.
    assign div_start = bus.snap_req && (state_q == StIdle);
    assign dividend  = Q_W'(cnt[NUM_IDX]) << FRAC_W;
    assign divisor   = Q_W'(cnt[DEN_IDX]);

    pmc_seq_divider #(
        .Q_W (Q_W)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quotient),
        .div0     (div_div0)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            ratio_q       <= '0;
            busy_q        <= 1'b0;
            ratio_valid_q <= 1'b0;
            div0_q        <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            case (state_q)
                StIdle: begin
                    if (div_start) begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            shadow_q[i] <= cnt[i];
                        end
                        ratio_valid_q <= 1'b0;
                        div0_q        <= 1'b0;
                        busy_q        <= 1'b1;
                        state_q       <= StDiv;
                    end
                end
                StDiv: begin
                    if (div_done || !div_busy) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    ratio_q       <= div_quotient;
                    div0_q        <= div_div0;
                    ratio_valid_q <= 1'b1;
                    busy_q        <= 1'b0;
                    state_q       <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    logic [CNT_W-1:0] rd_word;

    always_comb begin
        rd_word = '0;
        if (32'(bus.rd_sel) < NUM_CH) begin
            rd_word = shadow_q[bus.rd_sel];
        end
    end

    assign bus.rd_data     = OUT_W'(zext(OUT_W_MAX'(rd_word), CNT_W));
    assign bus.ratio       = OUT_W'(zext(OUT_W_MAX'(ratio_q), Q_W));
    assign bus.ovf         = ovf_vec;
    assign bus.busy        = busy_q;
    assign bus.ratio_valid = ratio_valid_q;
    assign bus.div0        = div0_q;

endmodule

// File: doc/pmc_bank.md
Name: pmc_bank

Overview:
- Parametrised performance-monitoring counter bank for the pipelined processor.
- Holds NUM_CH event counters with selectable wrap or saturate mode and sticky overflow flags.
- On request, takes an atomic snapshot of all counters into shadow registers. It then computes a fixed-point ratio of two snapshotted channels, e.g. cycles/instructions = CPI, using a multi-cycle divider.
- Sits beside the pipeline. Event strobes come from the control and hazard units. Outputs are zero-extended to the vector-register width for software readout.

Parameters:
- NUM_CH, 8, number of event counters (2..32).
- CNT_W, 32, counter width in bits.
- FRAC_W, 8, fractional bits of the ratio result (Q(CNT_W).FRAC_W).
- OUT_W, 256, readout bus width; must be >= CNT_W+FRAC_W.
- NUM_IDX, 0, channel used as ratio numerator.
- DEN_IDX, 1, channel used as ratio denominator.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  global count enable.
- event_in  in  NUM_CH  per-channel increment strobes, one count per cycle when high.
- sat_mode  in  1  1 = saturate at max, 0 = wrap to 0.
- freeze  in  1  hold all counters; events ignored.
- clear  in  1  synchronous clear of counters and ovf.
- snap_req  in  1  single-cycle snapshot/compute request.
- rd_sel  in  $clog2(NUM_CH)  shadow channel selected for readout.
- rd_data  out  OUT_W  {zeros, shadow[rd_sel]}, combinational from shadow.
- ovf  out  NUM_CH  sticky per-channel overflow flags (live).
- busy  out  1  snapshot/divide in progress.
- ratio  out  OUT_W  {zeros, quotient[CNT_W+FRAC_W-1:0]}.
- ratio_valid  out  1  ratio holds the result of the latest snapshot.
- div0  out  1  latest snapshot had a zero denominator.

Behaviour:
- Reset (async): all counters, shadows, ovf, ratio, busy, ratio_valid and div0 go to 0. FSM goes to IDLE. Reset mid-divide aborts with no result.
- Counter i update, priority order:
  - clear: cnt=0, ovf=0.
  - else freeze or !en: hold.
  - else event_in[i] with cnt==max: wrap mode gives cnt=0; sat mode holds max. Both set ovf[i]=1.
  - else event_in[i]: cnt+1.
- ovf stays high until clear or reset. Changing sat_mode has no effect on existing values.
- Snapshot: snap_req is accepted only in IDLE. At the accepting edge, every shadow[i] takes the pre-edge cnt[i], and the counter updates of that same edge still apply.
  - clear in the same cycle: the snapshot holds the pre-clear values.
  - At the same edge: ratio_valid=0, div0=0, busy=1, FSM goes to DIV.
- snap_req while busy is ignored: no shadow change, no restart.
- FSM states:
  - IDLE: waits for snap_req.
  - DIV: restoring divide of (shadow[NUM_IDX] << FRAC_W) by shadow[DEN_IDX], one quotient bit per cycle, MSB first, Q_W = CNT_W+FRAC_W iterations.
  - DONE: one cycle; ratio is written, ratio_valid=1, busy=0 at the exit edge; returns to IDLE.
- Latency: snap_req accepted at edge k → ratio_valid rises at edge k+Q_W+1. busy is high for exactly Q_W+1 cycles.
- Denominator zero: DIV is skipped. The FSM goes straight to DONE, then ratio = all-ones (Q_W bits), div0=1, ratio_valid=1 at edge k+2.
- Quotient is truncated, not rounded. It is computed in Q_W+1-bit remainder arithmetic, so there is no intermediate overflow.
- ratio and ratio_valid hold until the next accepted snap_req or reset. Counters keep counting throughout.
- rd_data always reflects the shadow registers, never the live counters.

Decomposition:
- Package pmc_pkg:
  - FSM state enum (IDLE, DIV, DONE).
  - Default constants for CNT_W and FRAC_W.
  - Helper function for zero-extension to OUT_W.
- Sub-module pmc_seq_divider:
  - Ports: start, dividend, divisor, busy, done, quotient, div0.
  - Parametrised by Q_W.
  - Owns the iteration counter and the remainder register.
- The counter array is a generate loop in pmc_bank.

Test Plan (NUM_CH=4, CNT_W=8, FRAC_W=8, NUM_IDX=0, DEN_IDX=1 unless noted):
- Event pulses: ch0 = 10, ch1 = 4, then snap_req → ratio_valid exactly 17 cycles after acceptance; ratio = 0x0280 (2.5); div0 = 0; rd_sel=0 gives rd_data = 10.
- 300 events on ch2, wrap mode → cnt2 = 44, ovf[2] = 1. Repeat in sat mode → cnt2 = 255, ovf[2] = 1. clear → cnt2 = 0, ovf = 0.
- ch1 = 0 at snapshot → ratio = 0xFFFF, div0 = 1, ratio_valid two edges after acceptance.
- snap_req re-asserted at the 5th busy cycle, with ch0 changed meanwhile → shadows unchanged, single result, busy length still 17.
- clear + snap_req + event_in[0] in the same cycle with cnt0 = 7 → shadow0 = 7, cnt0 = 0 afterwards. freeze high for 5 cycles of events → counters unchanged.
- reset asserted mid-DIV → busy = 0, ratio_valid = 0, ratio = 0 immediately (async). The next snap_req completes normally.
